// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control path: FSM states, opcode/op
// encodings, ALU and write-back selects, and register-number select helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // One-hot register-field selects; all-zero yields register number 0.
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  function automatic logic [2:0] reg_sel(input logic [2:0] nsel,
                                         input logic [2:0] rn,
                                         input logic [2:0] rd,
                                         input logic [2:0] rm);
    return ({3{nsel[2]}} & rn) | ({3{nsel[1]}} & rd) | ({3{nsel[0]}} & rm);
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction decoder: splits the IR into fields, muxes register
// numbers by one-hot selects and sign-extends the immediates.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  input  logic [2:0]  i_rsel,
  input  logic [2:0]  i_wsel,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [2:0]  o_readnum,
  output logic [2:0]  o_writenum,
  output logic [1:0]  o_shift,
  output logic [15:0] o_sximm5,
  output logic [15:0] o_sximm8
);

  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [2:0] w_rm;

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign w_rn     = i_ir[10:8];
  assign w_rd     = i_ir[7:5];
  assign o_shift  = i_ir[4:3];
  assign w_rm     = i_ir[2:0];

  assign o_readnum  = reg_sel(i_rsel, w_rn, w_rd, w_rm);
  assign o_writenum = reg_sel(i_wsel, w_rn, w_rd, w_rm);

  assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};
  assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};

endmodule

// File: rtl/vDFFE.sv
// Load-enabled register with asynchronous active-high clear.
module vDFFE #(
  parameter int n = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     out <= '0;
    else if (en) out <= in;
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore control FSM driving the datapath.
// Outputs depend only on the current state and the latched instruction.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [1:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_t      r_state;
  logic [15:0] w_ir;
  logic        w_ir_en;
  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rsel;
  logic [2:0]  w_wsel;
  logic        w_is_movimm;
  logic        w_is_movreg;
  logic        w_is_alu;
  logic        w_is_cmp;
  logic        w_is_mvn;

  assign w       = (r_state == S_WAIT);
  assign w_ir_en = load & w;
  assign bsel    = 1'b0;

  vDFFE #(.n(16)) u_ir (
    .clk (clk),
    .rst (reset),
    .en  (w_ir_en),
    .in  (in),
    .out (w_ir)
  );

  instr_decoder u_dec (
    .i_ir       (w_ir),
    .i_rsel     (w_rsel),
    .i_wsel     (w_wsel),
    .o_opcode   (w_opcode),
    .o_op       (w_op),
    .o_readnum  (readnum),
    .o_writenum (writenum),
    .o_shift    (shift),
    .o_sximm5   (sximm5),
    .o_sximm8   (sximm8)
  );

  assign w_is_movimm = (w_opcode == OPC_MOV) && (w_op == OP_MOV_IMM);
  assign w_is_movreg = (w_opcode == OPC_MOV) && (w_op == OP_MOV_REG);
  assign w_is_alu    = (w_opcode == OPC_ALU);
  assign w_is_cmp    = w_is_alu && (w_op == ALU_SUB);
  assign w_is_mvn    = w_is_alu && (w_op == ALU_MVN);

  // DECODE sees the IR written on the same edge that left WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:      if (s) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_movimm)                r_state <= S_WRITE_IMM;
          else if (w_is_movreg || w_is_mvn) r_state <= S_GET_B;
          else if (w_is_alu)              r_state <= S_GET_A;
          else                            r_state <= S_WAIT;
        end
        S_WRITE_IMM: r_state <= S_WAIT;
        S_GET_A:     r_state <= S_GET_B;
        S_GET_B:     r_state <= S_ALU;
        S_ALU:       r_state <= w_is_cmp ? S_WAIT : S_WRITE_REG;
        S_WRITE_REG: r_state <= S_WAIT;
        default:     r_state <= S_WAIT;
      endcase
    end
  end

  always_comb begin
    vsel   = VSEL_C;
    write  = 1'b0;
    loada  = 1'b0;
    loadb  = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    asel   = 1'b0;
    ALUop  = ALU_ADD;
    w_rsel = NSEL_NONE;
    w_wsel = NSEL_NONE;
    case (r_state)
      S_WRITE_IMM: begin
        write  = 1'b1;
        vsel   = VSEL_IMM8;
        w_wsel = NSEL_RN;
      end
      S_GET_A: begin
        loada  = 1'b1;
        w_rsel = NSEL_RN;
      end
      S_GET_B: begin
        loadb  = 1'b1;
        w_rsel = NSEL_RM;
      end
      S_ALU: begin
        ALUop = w_is_alu ? w_op : ALU_ADD;
        asel  = w_is_movreg || w_is_mvn;
        loads = w_is_cmp;
        loadc = !w_is_cmp;
      end
      S_WRITE_REG: begin
        write  = 1'b1;
        vsel   = VSEL_C;
        w_wsel = NSEL_RD;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes the expected per-cycle
// output trace from a phase-level instruction model; a negedge monitor checks it.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [1:0]  vsel;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [15:0] sximm5;
  logic [15:0] sximm8;

  cpu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .load     (load),
    .in       (in),
    .w        (w),
    .vsel     (vsel),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .readnum  (readnum),
    .writenum (writenum),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

  typedef struct packed {
    logic        w;
    logic [1:0]  vsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
  } outs_t;

  typedef enum {PH_WAIT, PH_DECODE, PH_WIMM, PH_GA, PH_GB, PH_ALU, PH_WREG} phase_t;

  typedef struct {
    outs_t o;
    string tag;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_ir;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] sext(input int unsigned v, input int unsigned bits);
    int signed x;
    x = int'(v);
    if (v >= (32'd1 << (bits - 1))) x = x - int'(32'd1 << bits);
    return x[15:0];
  endfunction

  function automatic outs_t expect_out(input phase_t p, input logic [15:0] ir);
    outs_t      o;
    logic [2:0] opc;
    logic [1:0] op;
    o        = '0;
    opc      = ir[15:13];
    op       = ir[12:11];
    o.shift  = ir[4:3];
    o.sximm5 = sext(32'(ir[4:0]), 5);
    o.sximm8 = sext(32'(ir[7:0]), 8);
    case (p)
      PH_WAIT: o.w = 1'b1;
      PH_WIMM: begin
        o.write = 1'b1; o.writenum = ir[10:8]; o.vsel = 2'd2;
      end
      PH_GA: begin
        o.readnum = ir[10:8]; o.loada = 1'b1;
      end
      PH_GB: begin
        o.readnum = ir[2:0]; o.loadb = 1'b1;
      end
      PH_ALU: begin
        if (opc == 3'd5) o.aluop = op;
        o.asel = (opc == 3'd6) || (opc == 3'd5 && op == 2'd3);
        if (opc == 3'd5 && op == 2'd1) o.loads = 1'b1;
        else                           o.loadc = 1'b1;
      end
      PH_WREG: begin
        o.write = 1'b1; o.writenum = ir[7:5]; o.vsel = 2'd0;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("w=%b vsel=%b wr=%b la=%b lb=%b lc=%b ls=%b asel=%b bsel=%b sh=%b alu=%b rn=%0d wn=%0d x5=%h x8=%h",
                     o.w, o.vsel, o.write, o.loada, o.loadb, o.loadc, o.loads, o.asel, o.bsel,
                     o.shift, o.aluop, o.readnum, o.writenum, o.sximm5, o.sximm8);
  endfunction

  function automatic void push(input phase_t p, input logic [15:0] ir);
    exp_t e;
    e.o   = expect_out(p, ir);
    e.tag = $sformatf("%s ir=%h", p.name(), ir);
    exp_q.push_back(e);
  endfunction

  function automatic bit is_defined(input logic [15:0] ir);
    return (ir[15:13] == 3'd5) || (ir[15:11] == 5'b11010) || (ir[15:11] == 5'b11000);
  endfunction

  // Phase sequence of one instruction after the edge that samples s.
  function automatic void push_trace(input logic [15:0] ir);
    phase_t     ph[$];
    logic [2:0] opc;
    logic [1:0] op;
    opc = ir[15:13];
    op  = ir[12:11];
    ph.push_back(PH_DECODE);
    if (opc == 3'd6 && op == 2'd2) begin
      ph.push_back(PH_WIMM);
    end else if (opc == 3'd5) begin
      if (op != 2'd3) ph.push_back(PH_GA);
      ph.push_back(PH_GB);
      ph.push_back(PH_ALU);
      if (op != 2'd1) ph.push_back(PH_WREG);
    end else if (opc == 3'd6 && op == 2'd0) begin
      ph.push_back(PH_GB);
      ph.push_back(PH_ALU);
      ph.push_back(PH_WREG);
    end
    ph.push_back(PH_WAIT);
    foreach (ph[i]) push(ph[i], ir);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t  e;
    outs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {w, vsel, write, loada, loadb, loadc, loads, asel, bsel,
           shift, ALUop, readnum, writenum, sximm5, sximm8};
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL out[%s]: got %s / want %s", e.tag, fmt(a), fmt(e.o));
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles still pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic step(input logic [15:0] ir, input logic ld, input logic st);
    @(negedge clk);
    #1;
    in   = ir;
    load = ld;
    s    = st;
    @(posedge clk);
    #1;
    if (ld) m_ir = ir;
    s    = 1'b0;
    load = 1'b0;
    if (st) push_trace(m_ir);
    else    push(PH_WAIT, m_ir);
    wait_drain();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 6))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2, 3, 4, 5: r[15:13] = 3'b101;
      default: while (is_defined(r)) r = 16'($urandom);
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] ir;
    reset = 1'b1;
    s     = 1'b0;
    load  = 1'b0;
    in    = '0;
    m_ir  = '0;

    push(PH_WAIT, 16'h0000);
    push(PH_WAIT, 16'h0000);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    wait_drain();

    step(16'hD1FE, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    step(16'hA148, 1'b1, 1'b1);
    step(16'hA900, 1'b1, 1'b1);
    step(16'hB860, 1'b1, 1'b1);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h1234, 1'b0, 1'b1);
    step(16'hC01A, 1'b1, 1'b1);
    step(16'hD57F, 1'b1, 1'b1);
    step(16'hD680, 1'b1, 1'b1);

    // Reset during GET_B of ADD: immediate return to WAIT, IR cleared, no write.
    @(negedge clk);
    #1;
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk);
    #1;
    m_ir = 16'hA148; s = 1'b0; load = 1'b0;
    push(PH_DECODE, m_ir);
    push(PH_GA, m_ir);
    push(PH_GB, m_ir);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    m_ir  = '0;
    #1;
    checks++;
    if (!(w === 1'b1 && write === 1'b0 && loadb === 1'b0 && sximm8 === 16'h0000)) begin
      errors++;
      $display("FAIL async_reset: got w=%b write=%b loadb=%b x8=%h / want w=1 write=0 loadb=0 x8=0000",
               w, write, loadb, sximm8);
    end
    push(PH_WAIT, m_ir);
    push(PH_WAIT, m_ir);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    wait_drain();
    repeat (3) step(16'hFFFF, 1'b0, 1'b0);

    // Load pulsed during GET_A must not disturb the running ADD.
    @(negedge clk);
    #1;
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk);
    #1;
    m_ir = 16'hA148; s = 1'b0; load = 1'b0;
    push_trace(m_ir);
    repeat (2) @(negedge clk);
    #1;
    in = 16'hD007; load = 1'b1;
    @(negedge clk);
    #1;
    load = 1'b0;
    wait_drain();
    step(16'h0000, 1'b0, 1'b0);

    for (int k = 0; k < 120; k++) begin
      ir = rand_instr();
      case ($urandom_range(0, 4))
        0: step(ir, 1'b1, 1'b0);
        1: step(ir, 1'b0, 1'b0);
        2: begin
          step(ir, 1'b1, 1'b0);
          step(16'($urandom), 1'b0, 1'b1);
        end
        default: step(ir, 1'b1, 1'b1);
      endcase
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
